// File: rtl/ppu_oam_port.sv
// PPU OAM register port: decodes $2003/$2004 accesses, owns the OAM array,
// tracks DMA bursts and serves the sprite-evaluation read port.
module ppu_oam_port #(
    parameter int OAM_DEPTH = 256,
    parameter int BURST_LEN = 256,
    parameter bit ATTR_MASK = 1'b1
) (
    input  logic                              CLK,
    input  logic                              n_RES,
    input  logic                              n_DBE,
    input  logic [2:0]                        RS,
    input  logic                              RnW,
    input  logic [7:0]                        DB_in,
    output logic [7:0]                        DB_out,
    output logic                              DB_oe,
    input  logic                              BLNK,
    input  logic [$clog2(OAM_DEPTH)-1:0]      OAM_rd_addr,
    output logic [7:0]                        OAM_rd_data,
    output logic [$clog2(OAM_DEPTH)-1:0]      OAMADDR,
    output logic [$clog2(BURST_LEN+1)-1:0]    burst_cnt,
    output logic                              burst_done,
    output logic                              wr_ignored
);

    localparam int AW = $clog2(OAM_DEPTH);
    localparam int CW = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {IDLE, COMMIT, HOLD} state_t;

    state_t         state;
    logic           dbe_p0;
    logic [2:0]     rs_p1;
    logic           rnw_p1;
    logic [7:0]     db_p1;
    logic [7:0]     mem [OAM_DEPTH];
    logic           start;
    logic           oamaddr_wr;
    logic           oamdata_wr;
    logic           oamdata_rd;
    logic           mem_we;
    logic [CW-1:0]  cnt_inc;
    logic [7:0]     rd_byte;

    // Attribute bytes (addr[1:0]==2) have unimplemented bits [4:2] that read as zero.
    function automatic logic [7:0] mask_byte(input logic [7:0] d, input logic [1:0] a);
        if (ATTR_MASK && a == 2'b10)
            return d & 8'hE3;
        return d;
    endfunction

    assign start      = (state == IDLE) && !n_DBE && dbe_p0;
    assign oamaddr_wr = (state == COMMIT) && !rnw_p1 && (rs_p1 == 3'd3);
    assign oamdata_wr = (state == COMMIT) && !rnw_p1 && (rs_p1 == 3'd4);
    assign oamdata_rd = (state == COMMIT) &&  rnw_p1 && (rs_p1 == 3'd4);
    assign mem_we     = oamdata_wr && BLNK && n_RES;
    assign cnt_inc    = burst_cnt + CW'(1);
    assign rd_byte    = mask_byte(mem[OAMADDR], OAMADDR[1:0]);

    // Stage p1: bus fields captured once, on the access start cycle.
    always_ff @(posedge CLK) begin
        if (start) begin
            rs_p1  <= RS;
            rnw_p1 <= RnW;
            db_p1  <= DB_in;
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we)
            mem[OAMADDR] <= db_p1;
    end

    always_ff @(posedge CLK or negedge n_RES) begin
        if (!n_RES)
            OAM_rd_data <= '0;
        else
            OAM_rd_data <= mask_byte(mem[OAM_rd_addr], OAM_rd_addr[1:0]);
    end

    // Stage p2: commit of the captured access, then hold until the CPU releases n_DBE.
    always_ff @(posedge CLK or negedge n_RES) begin
        if (!n_RES) begin
            state      <= IDLE;
            dbe_p0     <= 1'b1;
            OAMADDR    <= '0;
            burst_cnt  <= '0;
            DB_out     <= '0;
            DB_oe      <= 1'b0;
            burst_done <= 1'b0;
            wr_ignored <= 1'b0;
        end else begin
            dbe_p0     <= n_DBE;
            burst_done <= 1'b0;
            wr_ignored <= 1'b0;
            case (state)
                IDLE: begin
                    if (start)
                        state <= COMMIT;
                end
                COMMIT: begin
                    state <= HOLD;
                    if (oamaddr_wr) begin
                        OAMADDR   <= db_p1[AW-1:0];
                        burst_cnt <= '0;
                    end else if (oamdata_wr) begin
                        if (BLNK) begin
                            OAMADDR <= OAMADDR + AW'(1);
                            if (cnt_inc == CW'(BURST_LEN)) begin
                                burst_cnt  <= '0;
                                burst_done <= 1'b1;
                            end else begin
                                burst_cnt <= cnt_inc;
                            end
                        end else begin
                            wr_ignored <= 1'b1;
                        end
                    end else if (oamdata_rd) begin
                        DB_out <= rd_byte;
                        DB_oe  <= 1'b1;
                    end
                end
                HOLD: begin
                    if (n_DBE) begin
                        state <= IDLE;
                        DB_oe <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ppu_oam_port.sv
// Scoreboard bench for ppu_oam_port: a byte-array model of OAM/OAMADDR/burst
// counting queues expected responses; a monitor pops them as the DUT presents them.
module tb_ppu_oam_port;

    logic       CLK = 1'b0;
    logic       n_RES = 1'b0;
    logic       n_DBE = 1'b1;
    logic [2:0] RS = 3'd0;
    logic       RnW = 1'b1;
    logic [7:0] DB_in = 8'h00;
    logic       BLNK = 1'b1;
    logic [7:0] OAM_rd_addr = 8'h00;
    logic [7:0] DB_out;
    logic       DB_oe;
    logic [7:0] OAM_rd_data;
    logic [7:0] OAMADDR;
    logic [8:0] burst_cnt;
    logic       burst_done;
    logic       wr_ignored;

    ppu_oam_port #(.OAM_DEPTH(256), .BURST_LEN(256), .ATTR_MASK(1'b1)) dut (
        .CLK(CLK), .n_RES(n_RES), .n_DBE(n_DBE), .RS(RS), .RnW(RnW), .DB_in(DB_in),
        .DB_out(DB_out), .DB_oe(DB_oe), .BLNK(BLNK), .OAM_rd_addr(OAM_rd_addr),
        .OAM_rd_data(OAM_rd_data), .OAMADDR(OAMADDR), .burst_cnt(burst_cnt),
        .burst_done(burst_done), .wr_ignored(wr_ignored)
    );

    always #5 CLK = ~CLK;

    localparam int EV_READ = 0;
    localparam int EV_DONE = 1;
    localparam int EV_IGN  = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
        bit         chk;
    } ev_t;

    ev_t        exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         done_seen = 0;
    logic       oe_prev = 1'b0;

    logic [7:0] ref_mem [256];
    bit         known [256];
    int         ref_addr = 0;
    int         ref_cnt = 0;

    function automatic logic [7:0] model_mask(input logic [7:0] d, input int a);
        if (a % 4 == 2)
            return d & ~8'b0001_1100;
        return d;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pop_cmp(input int kind, input logic [7:0] data);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got kind %0d data 0x%0h, expected nothing", kind, data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind) begin
                n_bad++;
                $display("FAIL event_kind: got %0d, expected %0d", kind, e.kind);
            end else if (kind == EV_READ && e.chk && data !== e.data) begin
                n_bad++;
                $display("FAIL read_data: got 0x%0h, expected 0x%0h", data, e.data);
            end
        end
    endtask

    always @(negedge CLK) begin
        if (n_RES) begin
            if (DB_oe && !oe_prev) pop_cmp(EV_READ, DB_out);
            if (burst_done) begin
                done_seen++;
                pop_cmp(EV_DONE, 8'h00);
            end
            if (wr_ignored) pop_cmp(EV_IGN, 8'h00);
        end
        oe_prev = DB_oe;
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // One CPU/DMA access: model updated first, then the bus cycle is driven.
    task automatic access(input logic [2:0] rs, input logic rnw, input logic [7:0] d,
                          input int len, input logic blnk);
        ev_t e;
        if (rs == 3'd3 && !rnw) begin
            ref_addr = d;
            ref_cnt  = 0;
        end else if (rs == 3'd4 && !rnw) begin
            if (blnk) begin
                ref_mem[ref_addr] = d;
                known[ref_addr]   = 1'b1;
                ref_addr = (ref_addr + 1) % 256;
                ref_cnt++;
                if (ref_cnt == 256) begin
                    ref_cnt = 0;
                    e = '{kind: EV_DONE, data: 8'h00, chk: 1'b0};
                    exp_q.push_back(e);
                end
            end else begin
                e = '{kind: EV_IGN, data: 8'h00, chk: 1'b0};
                exp_q.push_back(e);
            end
        end else if (rs == 3'd4 && rnw) begin
            e = '{kind: EV_READ, data: model_mask(ref_mem[ref_addr], ref_addr), chk: known[ref_addr]};
            exp_q.push_back(e);
        end
        n_DBE = 1'b0;
        RS    = rs;
        RnW   = rnw;
        DB_in = d;
        BLNK  = blnk;
        repeat (len) tick;
        n_DBE = 1'b1;
        RS    = 3'($urandom);
        DB_in = 8'($urandom);
        RnW   = 1'($urandom);
        repeat (3) tick;
        check("oamaddr", 32'(OAMADDR), 32'(ref_addr));
        check("burst_cnt", 32'(burst_cnt), 32'(ref_cnt));
        check("db_oe_idle", 32'(DB_oe), 32'd0);
    endtask

    task automatic render_chk(input int a);
        OAM_rd_addr = 8'(a);
        tick;
        if (known[a]) check("render_port", 32'(OAM_rd_data), 32'(model_mask(ref_mem[a], a)));
    endtask

    task automatic rand_len(output int len);
        len = 2 + int'($urandom_range(0, 2));
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int len;
        int done0;
        for (int i = 0; i < 256; i++) known[i] = 1'b0;
        repeat (3) tick;
        check("rst_oamaddr", 32'(OAMADDR), 32'd0);
        check("rst_burst_cnt", 32'(burst_cnt), 32'd0);
        check("rst_db_out", 32'(DB_out), 32'd0);
        check("rst_db_oe", 32'(DB_oe), 32'd0);
        check("rst_rd_data", 32'(OAM_rd_data), 32'd0);
        check("rst_burst_done", 32'(burst_done), 32'd0);
        check("rst_wr_ignored", 32'(wr_ignored), 32'd0);
        n_RES = 1'b1;
        tick;

        // Full 256-byte DMA burst of alternating AA/55.
        access(3'd3, 1'b0, 8'h00, 2, 1'b1);
        done0 = done_seen;
        for (int i = 0; i < 256; i++) begin
            rand_len(len);
            access(3'd4, 1'b0, (i % 2 == 0) ? 8'hAA : 8'h55, len, 1'b1);
        end
        check("burst1_done_pulses", 32'(done_seen - done0), 32'd1);
        for (int a = 0; a < 256; a++) render_chk(a);

        // Wrap of OAMADDR past 0xFF.
        access(3'd3, 1'b0, 8'hFE, 2, 1'b1);
        access(3'd4, 1'b0, 8'h11, 2, 1'b1);
        access(3'd4, 1'b0, 8'h22, 3, 1'b1);
        render_chk(8'hFE);
        render_chk(8'hFF);

        // Attribute masking on both read paths.
        access(3'd3, 1'b0, 8'h02, 2, 1'b1);
        access(3'd4, 1'b0, 8'hFF, 2, 1'b1);
        access(3'd3, 1'b0, 8'h02, 2, 1'b1);
        access(3'd4, 1'b1, 8'h00, 4, 1'b1);
        OAM_rd_addr = 8'h02;
        tick;
        check("render_attr_mask", 32'(OAM_rd_data), 32'hE3);

        // Write while rendering is dropped.
        access(3'd3, 1'b0, 8'h10, 2, 1'b1);
        access(3'd4, 1'b0, 8'h77, 2, 1'b0);
        render_chk(8'h10);

        // Long n_DBE low period commits once.
        access(3'd4, 1'b0, 8'h5A, 12, 1'b1);
        render_chk(8'h10);
        render_chk(8'h11);

        // Randomized mixed traffic.
        for (int i = 0; i < 300; i++) begin
            logic [2:0] rs;
            int sel;
            sel = int'($urandom_range(0, 9));
            rs = (sel < 2) ? 3'd3 : (sel < 8) ? 3'd4 : 3'($urandom);
            rand_len(len);
            access(rs, 1'($urandom), 8'($urandom), len, ($urandom_range(0, 4) != 0));
        end
        for (int i = 0; i < 16; i++) render_chk(int'($urandom_range(0, 255)));

        // Reset in the middle of a burst, then a fresh full burst.
        access(3'd3, 1'b0, 8'h00, 2, 1'b1);
        done0 = done_seen;
        for (int i = 0; i < 100; i++) access(3'd4, 1'b0, 8'($urandom), 2, 1'b1);
        n_RES = 1'b0;
        #2;
        check("midrst_oamaddr", 32'(OAMADDR), 32'd0);
        check("midrst_burst_cnt", 32'(burst_cnt), 32'd0);
        check("midrst_rd_data", 32'(OAM_rd_data), 32'd0);
        ref_addr = 0;
        ref_cnt  = 0;
        tick;
        n_RES = 1'b1;
        tick;
        check("midrst_no_done", 32'(done_seen - done0), 32'd0);
        for (int i = 0; i < 256; i++) begin
            rand_len(len);
            access(3'd4, 1'b0, 8'($urandom), len, 1'b1);
        end
        check("burst2_done_pulses", 32'(done_seen - done0), 32'd1);

        repeat (5) tick;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
